eq_fir_sched: RTL

Time-multiplexed FIR scheduler for the EQ datapath. It shares one external 16x16 signed multiplier (an SB_MAC16 configured multiply-only with a registered output) across all taps of one audio channel. On each accepted input sample it shifts the delay line and issues one coefficient/sample operand pair per cycle to the multiplier. It accumulates the returned products, then rounds, saturates and presents one filtered sample. It sits between the I2S receive path and the I2S transmit path; coefficients are written from the SPI register side.

---
 rtl/eq_fir_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/eq_fir_sched.sv
`default_nettype none
// ============================================================================
// Module : eq_fir_sched
// Time-multiplexed FIR scheduler: one shared external multiplier, all taps.
// Rev    : 1.0  initial release
// ============================================================================
module eq_fir_sched #(
    parameter int N_TAPS  = 8,
    parameter int MUL_LAT = 1,
    parameter int ACCW    = 40
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [15:0]                 in_sample,
    output logic                        in_ready,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic [15:0]                 coef_data,
    output logic                        coef_err,
    output logic [15:0]                 mac_a,
    output logic [15:0]                 mac_b,
    output logic                        mac_ce,
    input  logic [31:0]                 mac_product,
    output logic                        out_valid,
    output logic [15:0]                 out_sample
);

    localparam int                      c_aw        = $clog2(N_TAPS);
    localparam logic [c_aw-1:0]         c_last      = c_aw'(N_TAPS - 1);
    localparam logic [MUL_LAT-1:0]      c_pend_mask = {MUL_LAT{1'b1}} >> 1;
    localparam logic signed [ACCW-1:0]  c_half      = {{(ACCW-15){1'b0}}, 15'h4000};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [15:0]            r_x [N_TAPS];
    logic [15:0]            r_c [N_TAPS];
    logic [c_aw-1:0]        r_k;
    logic signed [ACCW-1:0] r_acc;
    logic [MUL_LAT-1:0]     r_vpipe;
    logic [15:0]            r_out;
    logic                   r_coef_err;

    logic                   w_accept;
    logic                   w_ce;
    logic                   w_pvalid;
    logic                   w_pending;
    logic                   w_finish;
    logic [MUL_LAT-1:0]     w_ce_vec;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] w_acc_nxt;
    logic signed [ACCW-1:0] w_rnd;
    logic signed [ACCW-1:0] w_shift;
    logic [15:0]            w_sat;

    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_ce       = (r_state == S_RUN);
    assign w_pvalid   = r_vpipe[MUL_LAT-1];
    // Anything still in flight other than the product arriving this cycle
    assign w_pending  = |(r_vpipe & c_pend_mask);
    assign w_finish   = (r_state == S_DRAIN) && !w_pending;
    assign w_prod_ext = {{(ACCW-32){mac_product[31]}}, mac_product};
    assign w_acc_nxt  = w_pvalid ? (r_acc + w_prod_ext) : r_acc;

    always_comb begin
        w_ce_vec    = '0;
        w_ce_vec[0] = w_ce;
    end

    // Round half up, then clamp into Q1.15
    always_comb begin
        w_rnd   = w_acc_nxt + c_half;
        w_shift = w_rnd >>> 15;
        w_sat   = w_shift[15:0];
        if (w_shift[ACCW-1:15] != {(ACCW-15){w_shift[15]}}) begin
            w_sat = w_shift[ACCW-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)      w_state_nxt = S_RUN;
            S_RUN:   if (r_k == c_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_pending)    w_state_nxt = S_OUT;
            S_OUT:                      w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_acc      <= '0;
            r_vpipe    <= '0;
            r_out      <= '0;
            r_coef_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vpipe    <= (r_vpipe << 1) | w_ce_vec;
            r_coef_err <= coef_we && (r_state != S_IDLE);
            if (w_accept) begin
                r_acc <= '0;
                r_k   <= '0;
            end else begin
                r_acc <= w_acc_nxt;
                if (w_ce) begin
                    r_k <= r_k + 1'b1;
                end
            end
            if (w_finish) begin
                r_out <= w_sat;
            end
        end
    end

    // Delay line and coefficient RAM; a same-cycle write is visible to the run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_TAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            if (coef_we && (r_state == S_IDLE)) begin
                r_c[coef_addr] <= coef_data;
            end
            if (w_accept) begin
                for (int i = N_TAPS - 1; i > 0; i--) begin
                    r_x[i] <= r_x[i-1];
                end
                r_x[0] <= in_sample;
            end
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign mac_ce     = w_ce;
    assign mac_a      = w_ce ? r_c[r_k] : 16'h0000;
    assign mac_b      = w_ce ? r_x[r_k] : 16'h0000;
    assign out_valid  = (r_state == S_OUT);
    assign out_sample = r_out;
    assign coef_err   = r_coef_err;

endmodule
`default_nettype wire
